// File: rtl/uart_debug_master.sv
// UART-driven RIB bus master: 8N1 command frames in, one bus access, reply frames out.
// Optional inter-byte timeout for partial frames is built in when UDM_TIMEOUT_EN is defined.
module uart_debug_master #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_rx_pin,
  output logic        dbg_tx_pin,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic        grant_i,
  output logic        busy_o
);

  // state   | meaning
  // S_CMD   | waiting for a 'W' or 'R' command byte
  // S_ADDR  | collecting 4 address bytes, LSB first
  // S_DATA  | collecting 4 write-data bytes, LSB first
  // S_BUS   | req_o held until the first granted edge
  // S_RESP  | reply bytes on TX; back to S_CMD after the final stop bit

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int TW       = $clog2(BAUD_DIV) + 1;
  localparam logic [TW-1:0] BIT_LOAD  = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(BAUD_DIV / 2 - 1);
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h4B;

  if (BAUD_DIV < 4 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("uart_debug_master: BAUD_DIV must be >= 4 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  logic [1:0]    rx_sync;
  logic          rx_s;
  logic          rx_prev;
  rx_state_t     rx_state;
  logic [TW-1:0] rx_timer;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_byte;
  logic          rx_valid;

  logic          tx_go;
  logic          tx_multi;
  logic [31:0]   tx_word_in;
  logic          tx_active;
  logic [8:0]    tx_shift;
  logic [23:0]   tx_word;
  logic [3:0]    tx_bit;
  logic [1:0]    tx_left;
  logic [TW-1:0] tx_timer;
  logic          tx_end;

  state_t        state;
  logic          is_wr;
  logic [1:0]    idx;
  logic [23:0]   addr_sh;
  logic [23:0]   data_sh;
  logic          to_hit;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], dbg_rx_pin};
      rx_prev <= rx_s;
    end
  end

  // Edge-triggered start so a line still low after a framing error cannot retrigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= R_IDLE;
      rx_timer <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_timer <= HALF_LOAD;
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (rx_timer == '0) begin
            if (!rx_s) begin
              rx_timer <= BIT_LOAD;
              rx_bit   <= '0;
              rx_state <= R_DATA;
            end else begin
              rx_state <= R_IDLE;
            end
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        R_DATA: begin
          if (rx_timer == '0) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_timer <= BIT_LOAD;
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= R_STOP;
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        R_STOP: begin
          if (rx_timer == '0) begin
            if (rx_s) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end
            rx_state <= R_IDLE;
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Final stop bit of the last reply byte ends on this edge.
  assign tx_end = tx_active && (tx_timer == '0) && (tx_bit == 4'd9) && (tx_left == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_tx_pin <= 1'b1;
      tx_active  <= 1'b0;
      tx_shift   <= '1;
      tx_word    <= '0;
      tx_bit     <= '0;
      tx_left    <= '0;
      tx_timer   <= '0;
    end else if (tx_go) begin
      tx_active  <= 1'b1;
      dbg_tx_pin <= 1'b0;
      tx_shift   <= {1'b1, tx_word_in[7:0]};
      tx_word    <= tx_word_in[31:8];
      tx_left    <= tx_multi ? 2'd3 : 2'd0;
      tx_bit     <= '0;
      tx_timer   <= BIT_LOAD;
    end else if (tx_active) begin
      if (tx_timer != '0) begin
        tx_timer <= tx_timer - 1'b1;
      end else begin
        tx_timer <= BIT_LOAD;
        if (tx_bit == 4'd9) begin
          if (tx_left != 2'd0) begin
            dbg_tx_pin <= 1'b0;
            tx_shift   <= {1'b1, tx_word[7:0]};
            tx_word    <= {8'h00, tx_word[23:8]};
            tx_left    <= tx_left - 2'd1;
            tx_bit     <= '0;
          end else begin
            tx_active <= 1'b0;
          end
        end else begin
          dbg_tx_pin <= tx_shift[0];
          tx_shift   <= {1'b1, tx_shift[8:1]};
          tx_bit     <= tx_bit + 4'd1;
        end
      end
    end
  end

`ifdef UDM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (rx_valid || !(state == S_ADDR || state == S_DATA)) begin
      to_cnt <= '0;
    end else if (!to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CMD;
      is_wr      <= 1'b0;
      idx        <= '0;
      addr_sh    <= '0;
      data_sh    <= '0;
      busy_o     <= 1'b0;
      req_o      <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
      tx_go      <= 1'b0;
      tx_multi   <= 1'b0;
      tx_word_in <= '0;
    end else begin
      tx_go <= 1'b0;
      case (state)
        S_CMD: begin
          if (rx_valid && (rx_byte == CMD_WR || rx_byte == CMD_RD)) begin
            is_wr  <= (rx_byte == CMD_WR);
            idx    <= '0;
            busy_o <= 1'b1;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (to_hit) begin
            busy_o <= 1'b0;
            state  <= S_CMD;
          end else if (rx_valid) begin
            idx     <= idx + 2'd1;
            addr_sh <= {rx_byte, addr_sh[23:8]};
            if (idx == 2'd3) begin
              addr_o <= {rx_byte, addr_sh};
              if (is_wr) begin
                state <= S_DATA;
              end else begin
                req_o <= 1'b1;
                we_o  <= 1'b0;
                state <= S_BUS;
              end
            end
          end
        end
        S_DATA: begin
          if (to_hit) begin
            busy_o <= 1'b0;
            state  <= S_CMD;
          end else if (rx_valid) begin
            idx     <= idx + 2'd1;
            data_sh <= {rx_byte, data_sh[23:8]};
            if (idx == 2'd3) begin
              data_o <= {rx_byte, data_sh};
              req_o  <= 1'b1;
              we_o   <= 1'b1;
              state  <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (req_o && grant_i) begin
            tx_word_in <= is_wr ? {24'h0, ACK} : data_i;
            tx_multi   <= !is_wr;
            tx_go      <= 1'b1;
            req_o      <= 1'b0;
            we_o       <= 1'b0;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_end) begin
            busy_o <= 1'b0;
            state  <= S_CMD;
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_master.sv
// Self-checking bench for uart_debug_master: directed and randomized frames against a frame-level model.
module tb_uart_debug_master;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_rx_pin;
  logic        dbg_tx_pin;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic        grant_i;
  logic        busy_o;

  uart_debug_master #(
    .CLK_FREQ(1600000),
    .BAUD(100000),
    .TIMEOUT_CYC(2000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dbg_rx_pin(dbg_rx_pin),
    .dbg_tx_pin(dbg_tx_pin),
    .req_o(req_o),
    .we_o(we_o),
    .addr_o(addr_o),
    .data_o(data_o),
    .data_i(data_i),
    .grant_i(grant_i),
    .busy_o(busy_o)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int stall_target = 0;
  int stall_cnt = 0;
  int n_access = 0;
  int req_cycles = 0;
  int tx_bad = 0;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  logic        stable;
  logic [7:0]  txq[$];
  logic [7:0]  frame_q[$];

  // Bus side: grant after stall_target cycles of request, record the access.
  initial begin
    grant_i = 1'b0;
    forever begin
      @(negedge clk);
      if (req_o) begin
        if (stall_cnt == 0) begin
          acc_we = we_o;
          acc_addr = addr_o;
          acc_data = data_o;
        end else if (we_o !== acc_we || addr_o !== acc_addr || data_o !== acc_data) begin
          stable = 1'b0;
        end
        req_cycles++;
        grant_i = (stall_cnt >= stall_target);
        if (grant_i) n_access++;
        stall_cnt++;
      end else begin
        grant_i = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // TX decoder: mid-bit sampling of each 8N1 byte.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge dbg_tx_pin);
      repeat (BD / 2) @(posedge clk);
      #1;
      if (dbg_tx_pin === 1'b0) begin
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(posedge clk);
          #1;
          b[i] = dbg_tx_pin;
        end
        repeat (BD) @(posedge clk);
        #1;
        if (dbg_tx_pin === 1'b1) txq.push_back(b);
        else tx_bad++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    dbg_rx_pin = 1'b0;
    idle(BD);
    for (int i = 0; i < 8; i++) begin
      dbg_rx_pin = b[i];
      idle(BD);
    end
    dbg_rx_pin = stop;
    idle(BD);
    dbg_rx_pin = 1'b1;
  endtask

  task automatic make_frame(input logic wr);
    logic [31:0] a;
    logic [31:0] d;
    a = $urandom;
    d = $urandom;
    frame_q.delete();
    frame_q.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) frame_q.push_back(8'((a >> (8 * i)) & 32'hFF));
    if (wr) for (int i = 0; i < 4; i++) frame_q.push_back(8'((d >> (8 * i)) & 32'hFF));
  endtask

  // Expected access and reply come straight from the frame bytes and data_i.
  task automatic do_frame(input int stall, input string tag);
    logic        is_w;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [7:0]  er[$];
    logic        done;
    is_w = (frame_q[0] == 8'h57);
    ea = {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
    ed = is_w ? {frame_q[8], frame_q[7], frame_q[6], frame_q[5]} : 32'h0;
    if (is_w) er.push_back(8'h4B);
    else for (int i = 0; i < 4; i++) er.push_back(8'((data_i >> (8 * i)) & 32'hFF));
    txq.delete();
    n_access = 0;
    req_cycles = 0;
    stable = 1'b1;
    stall_target = stall;
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], 1'b1);
      if (i == 0) chk({tag, " busy_after_cmd"}, 32'(busy_o), 32'd1);
    end
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (!busy_o && txq.size() == er.size()) done = 1'b1;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " accesses"}, 32'(n_access), 32'd1);
    chk({tag, " req_cycles"}, 32'(req_cycles), 32'(stall + 1));
    chk({tag, " stable"}, 32'(stable), 32'd1);
    chk({tag, " we"}, 32'(acc_we), 32'(is_w));
    chk({tag, " addr"}, acc_addr, ea);
    if (is_w) chk({tag, " wdata"}, acc_data, ed);
    chk({tag, " addr_hold"}, addr_o, ea);
    chk({tag, " req_idle"}, 32'(req_o), 32'd0);
    chk({tag, " reply_len"}, 32'(txq.size()), 32'(er.size()));
    for (int i = 0; i < er.size(); i++)
      chk($sformatf("%s reply%0d", tag, i), (i < txq.size()) ? {24'h0, txq[i]} : 32'hFFFF_FFFF, {24'h0, er[i]});
  endtask

  initial begin
    rst = 1'b1;
    dbg_rx_pin = 1'b1;
    data_i = '0;
    idle(4);
    rst = 1'b0;
    @(negedge clk);
    chk("rst tx", 32'(dbg_tx_pin), 32'd1);
    chk("rst req", 32'(req_o), 32'd0);
    chk("rst we", 32'(we_o), 32'd0);
    chk("rst addr", addr_o, 32'h0);
    chk("rst data", data_o, 32'h0);
    chk("rst busy", 32'(busy_o), 32'd0);

    frame_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12};
    do_frame(0, "write");
    chk("write data_o", data_o, 32'h1234_5678);

    data_i = 32'hDEAD_BEEF;
    frame_q = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h20};
    do_frame(0, "read");

    data_i = $urandom;
    make_frame(1'b0);
    do_frame(5, "stall");

    txq.delete();
    n_access = 0;
    send_byte(8'h33, 1'b1);
    idle(20);
    chk("garbage busy", 32'(busy_o), 32'd0);
    send_byte(8'h57, 1'b0);
    idle(40);
    chk("framing busy", 32'(busy_o), 32'd0);
    chk("garbage accesses", 32'(n_access), 32'd0);
    chk("garbage reply", 32'(txq.size()), 32'd0);
    make_frame(1'b1);
    do_frame(0, "after_garbage");

    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst tx", 32'(dbg_tx_pin), 32'd1);
    chk("midrst req", 32'(req_o), 32'd0);
    chk("midrst we", 32'(we_o), 32'd0);
    chk("midrst addr", addr_o, 32'h0);
    chk("midrst data", data_o, 32'h0);
    chk("midrst busy", 32'(busy_o), 32'd0);
    idle(3);
    rst = 1'b0;
    data_i = $urandom;
    make_frame(1'b0);
    do_frame(0, "after_reset");

    n_access = 0;
    txq.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h01, 1'b1);
    idle(2100);
    chk("timeout accesses", 32'(n_access), 32'd0);
`ifdef UDM_TIMEOUT_EN
    chk("timeout busy", 32'(busy_o), 32'd0);
`else
    chk("timeout busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
`endif
    make_frame(1'b1);
    do_frame(1, "after_timeout");

    for (int k = 0; k < 5; k++) begin
      data_i = $urandom;
      make_frame(1'($urandom_range(0, 1)));
      do_frame(int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
    end

    chk("tx framing errors", 32'(tx_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_debug_master.md
Name: uart_debug_master

Overview:
- UART-driven bus initiator for the RIB master 2 slot: lets a host PC write and read any slave (rom, ram, uart, gpio) over a serial link.
- Receives 8N1 command frames on a dedicated RX pin and assembles address and data.
- Issues a single RIB access, then replies over a dedicated TX pin.
- Sits beside the core in the SoC; used for program download and memory peek/poke.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer truncation, must be >= 4).
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles (only with UDM_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- dbg_rx_pin  input  1  serial in, idle high
- dbg_tx_pin  output  1  serial out, idle high
- req_o  output  1  RIB request (to m2_req_i)
- we_o  output  1  RIB write enable (to m2_we_i)
- addr_o  output  32  RIB address (to m2_addr_i)
- data_o  output  32  RIB write data (to m2_data_i)
- data_i  input  32  RIB read data (from m2_data_o)
- grant_i  input  1  RIB grant for master 2; transfer completes on a clk edge where req_o && grant_i
- busy_o  output  1  high while a frame is in progress

Behaviour:
- Reset values: dbg_tx_pin=1, req_o=0, we_o=0, addr_o=0, data_o=0, busy_o=0. All FSMs go to idle. Reset at any point aborts the frame, bus access and reply.
- RX path:
  - dbg_rx_pin passes a 2-flop synchroniser.
  - A falling edge in RX idle starts the bit counter. The start bit is re-sampled at BAUD_DIV/2; if high, return to idle (glitch).
  - 8 data bits are sampled LSB first, each BAUD_DIV apart; the stop bit is sampled one BAUD_DIV later.
  - Stop bit 0 = frame error: byte dropped, RX returns to idle.
  - A valid byte raises a 1-cycle internal rx_valid.
- Frame format: CMD, ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24], then DATA0..DATA3 little-endian for writes only. CMD 0x57 ('W') = write, 0x52 ('R') = read.
- Parser FSM:
  - S_CMD: a valid CMD goes to S_ADDR; any other byte is ignored and the FSM stays in S_CMD.
  - S_ADDR: collects 4 bytes. After the 4th, goes to S_DATA (write) or S_BUS (read).
  - S_DATA: collects 4 bytes, then goes to S_BUS.
  - S_BUS:
    - On entry, req_o=1; we_o=1 for writes, 0 for reads. addr_o/data_o are stable.
    - Holds until the first clk edge with grant_i=1; on that edge data_i is latched (reads).
    - Next cycle: req_o=0, we_o=0, go to S_RESP. Access latency is 1 cycle when grant is immediate.
    - addr_o/data_o retain their last values after the access.
  - S_RESP: sends 0x4B ('K') for a write, or 4 read-data bytes LSB byte first, back-to-back. Returns to S_CMD after the final stop bit.
  - RX bytes arriving during S_BUS/S_RESP are discarded.
- TX: 8N1, start bit 0, LSB first, stop bit 1, each bit BAUD_DIV cycles. Consecutive reply bytes have no idle gap.
- busy_o rises the cycle after the CMD byte is accepted and falls the cycle the reply's final stop bit ends.
- Counters: bit timer width = clog2(BAUD_DIV)+1. Byte index is 2 bits and wraps 3->0 on completion.

Optional Feature:
- Macro UDM_TIMEOUT_EN.
- Defined: a counter clears on each rx_valid and increments in S_ADDR/S_DATA. When it reaches TIMEOUT_CYC, the parser drops the partial frame, returns to S_CMD and clears busy_o. No bus access and no reply occur.
- Undefined: no counter logic; a partial frame waits indefinitely for its next byte.

Test Plan (CLK_FREQ=1600000, BAUD=100000 -> BAUD_DIV=16, TIMEOUT_CYC=2000):
- Write: send 57 00 00 00 10 78 56 34 12, grant_i=1 -> one req_o pulse with we_o=1, addr_o=0x10000000, data_o=0x12345678; reply byte 0x4B; busy_o low afterwards.
- Read: send 52 04 00 00 20, data_i=0xDEADBEEF, grant_i=1 -> req_o=1, we_o=0, addr_o=0x20000004 for exactly 1 cycle; TX bytes EF BE AD DE.
- Grant stall: read frame with grant_i low 5 cycles -> req_o held 6 cycles, addr stable; single access; correct reply.
- Garbage/framing: send 0x33, then a byte with stop bit 0, then a valid write frame -> first two ignored, no bus activity; write completes normally.
- Reset mid-frame: assert rst after 3 address bytes -> all outputs at reset values; a following full read frame succeeds.
- Timeout (UDM_TIMEOUT_EN): send 57 01, idle 2100 cycles -> busy_o falls, no req_o; a subsequent full frame succeeds. Without the macro: busy_o stays high.
